tone_square_gen: RTL and testbench
==================================

Name: tone_square_gen

Overview:
- Downstream consumer of the sound-request stage.
- Takes the tone enable and the half-period value that stage produces, and drives a glitch-free square wave to the speaker/buzzer pin.
- Tone changes and stops take effect only at full-period boundaries, so no runt pulses reach the speaker.
- Enforces a minimum number of audible periods per tone and reports tone activity and a completed-period count.

Parameters:
- WIDTH, 52: width of the half-period input and the internal down-counter.
- MIN_HALF, 2: smallest legal half-period in clk cycles; smaller non-zero requests are clamped up to it.
- MIN_PERIODS, 4: full periods always emitted once a tone starts, even if the enable drops earlier.
- CNT_W, 16: width of the completed-period counter.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_enable  input  1  tone request from the sound stage; level-sensitive.
- sonido  input  WIDTH  requested half-period in clk cycles; 0 means silence.
- speaker  output  1  square-wave output, registered.
- busy  output  1  high whenever state is not IDLE.
- period_cnt  output  CNT_W  full periods completed since the current tone started; saturates at all-ones.
- min_done  output  1  high once period_cnt reaches MIN_PERIODS in the current tone.

Behaviour:
- Reset (async assert, sync release) forces:
  - state = IDLE; speaker, busy, min_done = 0; period_cnt = 0; counter and half_reg = 0.
- "req" is defined as s_enable = 1 and sonido != 0.
- hp is defined as max(sonido, MIN_HALF) when sonido != 0.
- States: IDLE, RUN_HI, RUN_LO.
- IDLE:
  - speaker = 0.
  - On an edge with req: half_reg <= hp; counter <= hp-1; speaker <= 1; period_cnt <= 0; min_done <= 0; go to RUN_HI.
  - Latency: speaker is high in the cycle after the first edge that samples req.
- RUN_HI:
  - Each edge: counter <= counter-1.
  - At the edge where counter == 0: speaker <= 0; counter <= half_reg-1; go to RUN_LO.
  - speaker is therefore high for exactly half_reg cycles.
- RUN_LO:
  - Decrements the same way. At the edge where counter == 0, a full period has ended:
    - period_cnt <= period_cnt+1, saturating.
    - min_done <= 1 if period_cnt+1 >= MIN_PERIODS.
  - Then, at that same edge:
    - If req, or period_cnt+1 < MIN_PERIODS: continue. half_reg <= hp if req, otherwise the old half_reg is kept. counter <= new half_reg-1; speaker <= 1; go to RUN_HI.
    - Otherwise: go to IDLE with speaker held at 0.
- sonido changes mid-period are ignored until the next RUN_LO terminal edge. The value sampled on that edge is used for the whole next period.
- s_enable is level-sampled only at period boundaries; drops and returns between boundaries have no effect.
- busy is combinational from state: 1 in RUN_HI and RUN_LO.
- An s_enable pulse of any length that starts a tone yields at least MIN_PERIODS full periods at the start-time half-period.
- s_enable = 1 with sonido = 0 in IDLE: no start.
- sonido = 0 at a boundary while the minimum is unmet: the current half_reg is kept.
- period_cnt and min_done hold their last values in IDLE until the next start.
- The counter never underflows: reload happens at counter == 0.
- Reset mid-tone drops speaker to 0 immediately (asynchronous).

Test Plan:
- Reset: reset_n = 0 during a running tone -> speaker, busy, period_cnt, min_done all 0 in the same cycle. Release with s_enable = 0 -> stays IDLE.
- Basic tone: sonido = 4, s_enable held 1 from edge 0 -> speaker high for cycles 1-4, low 5-8, high 9-12. period_cnt = 1 after edge 8; busy = 1 throughout.
- Clamp and zero:
  - sonido = 1 -> half_reg = 2, 4-cycle period.
  - sonido = 0 with s_enable = 1 -> no start, busy stays 0.
- Minimum periods: sonido = 3, s_enable high for 1 cycle -> exactly 4 periods (24 cycles), then IDLE. min_done = 1 and period_cnt = 4 at the end.
- Mid-period change: sonido 4 -> 6 during the first RUN_HI -> first period stays 8 cycles; the second period is 12 cycles.
- Stop timing: s_enable drops mid-RUN_HI of period 6 (minimum already met) -> speaker completes that high and low phase, then goes IDLE. No shortened pulse; period_cnt = 6.

Source files
------------

// File: rtl/tone_square_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_square_gen: glitch-free square-wave tone driver for a speaker pin.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tone_square_gen #(
  parameter int WIDTH       = 52,
  parameter int MIN_HALF    = 2,
  parameter int MIN_PERIODS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_enable,
  input  logic [WIDTH-1:0] sonido,
  output logic             speaker,
  output logic             busy,
  output logic [CNT_W-1:0] period_cnt,
  output logic             min_done
);

  localparam logic [1:0]       c_idle    = 2'd0;
  localparam logic [1:0]       c_run_hi  = 2'd1;
  localparam logic [1:0]       c_run_lo  = 2'd2;
  localparam logic [WIDTH-1:0] c_one_w   = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_min_hp  = WIDTH'(MIN_HALF);
  localparam logic [CNT_W:0]   c_one_c   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   c_min_per = (CNT_W+1)'(MIN_PERIODS);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic             speaker_q, speaker_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             min_done_q, min_done_d;

  logic             w_req;
  logic [WIDTH-1:0] w_hp;
  logic [WIDTH-1:0] w_half_next;
  logic [CNT_W:0]   w_cnt_plus;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_min_met;

  assign w_req       = s_enable && (sonido != '0);
  assign w_hp        = (sonido < c_min_hp) ? c_min_hp : sonido;
  assign w_half_next = w_req ? w_hp : half_q;
  // Minimum test uses the unsaturated count so a saturated counter still reads as met.
  assign w_cnt_plus  = {1'b0, period_cnt_q} + c_one_c;
  assign w_cnt_sat   = (&period_cnt_q) ? period_cnt_q : w_cnt_plus[CNT_W-1:0];
  assign w_min_met   = (w_cnt_plus >= c_min_per);

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    half_d       = half_q;
    speaker_d    = speaker_q;
    period_cnt_d = period_cnt_q;
    min_done_d   = min_done_q;
    case (state_q)
      c_idle: begin
        speaker_d = 1'b0;
        if (w_req) begin
          half_d       = w_hp;
          counter_d    = w_hp - c_one_w;
          speaker_d    = 1'b1;
          period_cnt_d = '0;
          min_done_d   = 1'b0;
          state_d      = c_run_hi;
        end
      end
      c_run_hi: begin
        if (counter_q == '0) begin
          speaker_d = 1'b0;
          counter_d = half_q - c_one_w;
          state_d   = c_run_lo;
        end else begin
          counter_d = counter_q - c_one_w;
        end
      end
      c_run_lo: begin
        if (counter_q == '0) begin
          period_cnt_d = w_cnt_sat;
          if (w_min_met) min_done_d = 1'b1;
          // Tone changes and stops only ever land here, at a full-period boundary.
          if (w_req || !w_min_met) begin
            half_d    = w_half_next;
            counter_d = w_half_next - c_one_w;
            speaker_d = 1'b1;
            state_d   = c_run_hi;
          end else begin
            speaker_d = 1'b0;
            state_d   = c_idle;
          end
        end else begin
          counter_d = counter_q - c_one_w;
        end
      end
      default: begin
        speaker_d = 1'b0;
        state_d   = c_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= c_idle;
      counter_q    <= '0;
      half_q       <= '0;
      speaker_q    <= 1'b0;
      period_cnt_q <= '0;
      min_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      half_q       <= half_d;
      speaker_q    <= speaker_d;
      period_cnt_q <= period_cnt_d;
      min_done_q   <= min_done_d;
    end
  end

  assign speaker    = speaker_q;
  assign busy       = (state_q == c_run_hi) || (state_q == c_run_lo);
  assign period_cnt = period_cnt_q;
  assign min_done   = min_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_square_gen.sv
`default_nettype none
// Directed testbench for tone_square_gen; each task checks its own scenario.
module tb_tone_square_gen;

  logic        clk;
  logic        reset_n;
  logic        s_enable;
  logic [51:0] sonido;
  logic        speaker;
  logic        busy;
  logic [15:0] period_cnt;
  logic        min_done;

  int checks = 0;
  int errors = 0;

  tone_square_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_enable   (s_enable),
    .sonido     (sonido),
    .speaker    (speaker),
    .busy       (busy),
    .period_cnt (period_cnt),
    .min_done   (min_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle at the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_enable = 1'b0; sonido = '0;
    tick(); tick();
    checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL reset_speaker got %0b want 0", speaker); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL reset_period_cnt got %0d want 0", period_cnt); end
    checks++; if (min_done !== 1'b0) begin errors++; $display("FAIL reset_min_done got %0b want 0", min_done); end
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    bit ok;
    logic exp_spk;
    sonido = 52'd4; s_enable = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      exp_spk = (e < 4) ? 1'b1 : (e < 8) ? 1'b0 : 1'b1;
      checks++; if (speaker !== exp_spk) begin errors++; $display("FAIL basic_speaker edge %0d got %0b want %0b", e, speaker, exp_spk); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy edge %0d got %0b want 1", e, busy); end
      if (e == 7) begin
        checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL basic_cnt_e7 got %0d want 0", period_cnt); end
      end
      if (e == 8) begin
        checks++; if (period_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt_e8 got %0d want 1", period_cnt); end
      end
    end
    s_enable = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got busy want idle"); end
    checks++; if (period_cnt !== 16'd4) begin errors++; $display("FAIL basic_final_cnt got %0d want 4", period_cnt); end
    checks++; if (min_done !== 1'b1) begin errors++; $display("FAIL basic_min_done got %0b want 1", min_done); end
  endtask

  task automatic test_clamp_zero();
    bit ok;
    logic exp_spk;
    sonido = 52'd1; s_enable = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_spk = ((e % 4) < 2) ? 1'b1 : 1'b0;
      checks++; if (speaker !== exp_spk) begin errors++; $display("FAIL clamp_speaker edge %0d got %0b want %0b", e, speaker, exp_spk); end
    end
    s_enable = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout got busy want idle"); end
    sonido = '0; s_enable = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy edge %0d got %0b want 0", e, busy); end
      checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL zero_speaker edge %0d got %0b want 0", e, speaker); end
    end
    s_enable = 1'b0;
  endtask

  task automatic test_min_periods();
    logic exp_spk;
    sonido = 52'd3; s_enable = 1'b1;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (e == 0) begin
        s_enable = 1'b0;
        checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL minp_start_cnt got %0d want 0", period_cnt); end
        checks++; if (min_done !== 1'b0) begin errors++; $display("FAIL minp_start_done got %0b want 0", min_done); end
      end
      if (e < 24) begin
        exp_spk = ((e % 6) < 3) ? 1'b1 : 1'b0;
        checks++; if (speaker !== exp_spk) begin errors++; $display("FAIL minp_speaker edge %0d got %0b want %0b", e, speaker, exp_spk); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL minp_busy edge %0d got %0b want 1", e, busy); end
      end
      if (e == 18) begin
        checks++; if (min_done !== 1'b0) begin errors++; $display("FAIL minp_done_e18 got %0b want 0", min_done); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL minp_end_busy got %0b want 0", busy); end
    checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL minp_end_speaker got %0b want 0", speaker); end
    checks++; if (period_cnt !== 16'd4) begin errors++; $display("FAIL minp_end_cnt got %0d want 4", period_cnt); end
    checks++; if (min_done !== 1'b1) begin errors++; $display("FAIL minp_end_done got %0b want 1", min_done); end
  endtask

  task automatic test_mid_change();
    bit ok;
    logic exp_spk;
    sonido = 52'd4; s_enable = 1'b1;
    for (int e = 0; e < 21; e++) begin
      tick();
      if (e == 0) sonido = 52'd6;
      exp_spk = (e < 4) ? 1'b1 : (e < 8) ? 1'b0 : (e < 14) ? 1'b1 : (e < 20) ? 1'b0 : 1'b1;
      checks++; if (speaker !== exp_spk) begin errors++; $display("FAIL change_speaker edge %0d got %0b want %0b", e, speaker, exp_spk); end
    end
    checks++; if (period_cnt !== 16'd2) begin errors++; $display("FAIL change_cnt got %0d want 2", period_cnt); end
    s_enable = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL change_timeout got busy want idle"); end
  endtask

  task automatic test_stop_timing();
    logic exp_spk;
    sonido = 52'd2; s_enable = 1'b1;
    for (int e = 0; e < 25; e++) begin
      tick();
      exp_spk = (e < 24 && (e % 4) < 2) ? 1'b1 : 1'b0;
      checks++; if (speaker !== exp_spk) begin errors++; $display("FAIL stop_speaker edge %0d got %0b want %0b", e, speaker, exp_spk); end
      checks++; if (busy !== (e < 24)) begin errors++; $display("FAIL stop_busy edge %0d got %0b want %0b", e, busy, (e < 24)); end
      if (e == 20) s_enable = 1'b0;
    end
    checks++; if (period_cnt !== 16'd6) begin errors++; $display("FAIL stop_cnt got %0d want 6", period_cnt); end
    checks++; if (min_done !== 1'b1) begin errors++; $display("FAIL stop_done got %0b want 1", min_done); end
  endtask

  task automatic test_async_reset();
    sonido = 52'd2; s_enable = 1'b1;
    for (int e = 0; e < 10; e++) tick();
    checks++; if (speaker !== 1'b1) begin errors++; $display("FAIL areset_pre_speaker got %0b want 1", speaker); end
    checks++; if (period_cnt !== 16'd2) begin errors++; $display("FAIL areset_pre_cnt got %0d want 2", period_cnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (speaker !== 1'b0) begin errors++; $display("FAIL areset_speaker got %0b want 0", speaker); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %0b want 0", busy); end
    checks++; if (period_cnt !== 16'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", period_cnt); end
    checks++; if (min_done !== 1'b0) begin errors++; $display("FAIL areset_done got %0b want 0", min_done); end
    s_enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_release_busy got %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp_zero();
    test_min_periods();
    test_mid_change();
    test_stop_timing();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
